// File: rtl/isa_types.sv
// Shared RV32I types for the execute path: opcodes, funct3/funct7 codes,
// architectural state and decoded-instruction records, plus ALU op decoding.
package isa_types;

   localparam int XLEN = 32;

   typedef enum logic [6:0] {
      OPCODE_OP_IMM = 7'b0010011,
      OPCODE_OP     = 7'b0110011,
      OPCODE_LUI    = 7'b0110111,
      OPCODE_AUIPC  = 7'b0010111,
      OPCODE_JAL    = 7'b1101111,
      OPCODE_JALR   = 7'b1100111,
      OPCODE_BRANCH = 7'b1100011,
      OPCODE_LOAD   = 7'b0000011,
      OPCODE_STORE  = 7'b0100011
   } opcode_t;

   localparam logic [2:0] FUNCT3_SB = 3'b000;
   localparam logic [2:0] FUNCT3_SH = 3'b001;
   localparam logic [2:0] FUNCT3_SW = 3'b010;

   localparam logic [2:0] FUNCT3_LB  = 3'b000;
   localparam logic [2:0] FUNCT3_LH  = 3'b001;
   localparam logic [2:0] FUNCT3_LW  = 3'b010;
   localparam logic [2:0] FUNCT3_LBU = 3'b100;
   localparam logic [2:0] FUNCT3_LHU = 3'b101;

   localparam logic [2:0] FUNCT3_BEQ  = 3'b000;
   localparam logic [2:0] FUNCT3_BNE  = 3'b001;
   localparam logic [2:0] FUNCT3_BLT  = 3'b100;
   localparam logic [2:0] FUNCT3_BGE  = 3'b101;
   localparam logic [2:0] FUNCT3_BLTU = 3'b110;
   localparam logic [2:0] FUNCT3_BGEU = 3'b111;

   localparam logic [2:0] FUNCT3_ADD_SUB = 3'b000;
   localparam logic [2:0] FUNCT3_SLL     = 3'b001;
   localparam logic [2:0] FUNCT3_SLT     = 3'b010;
   localparam logic [2:0] FUNCT3_SLTU    = 3'b011;
   localparam logic [2:0] FUNCT3_XOR     = 3'b100;
   localparam logic [2:0] FUNCT3_SRL_SRA = 3'b101;
   localparam logic [2:0] FUNCT3_OR      = 3'b110;
   localparam logic [2:0] FUNCT3_AND     = 3'b111;

   localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

   typedef enum logic [4:0] {
      ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_SRA,
      ALU_OR, ALU_AND, ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU,
      ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU
   } alu_op_t;

   typedef struct packed {
      logic [0:31][XLEN-1:0] xregs;
      logic [XLEN-1:0]       pc;
   } reg_state_t;

   typedef struct packed {
      logic [6:0]      opcode;
      logic [4:0]      rd;
      logic [4:0]      rs1;
      logic [4:0]      rs2;
      logic [2:0]      funct3;
      logic [6:0]      funct7;
      logic [XLEN-1:0] i_imm;
      logic [XLEN-1:0] s_imm;
      logic [XLEN-1:0] b_imm;
      logic [XLEN-1:0] u_imm;
      logic [XLEN-1:0] j_imm;
   } decoded_instruction_t;

   // funct7[5] selects SUB only for register-register ops; on OP_IMM it is immediate bits.
   function automatic alu_op_t alu_op_for(input logic [2:0] funct3, input logic alt,
                                          input logic is_reg);
      alu_op_t op;
      case (funct3)
         FUNCT3_ADD_SUB: op = (is_reg && alt) ? ALU_SUB : ALU_ADD;
         FUNCT3_SLL:     op = ALU_SLL;
         FUNCT3_SLT:     op = ALU_SLT;
         FUNCT3_SLTU:    op = ALU_SLTU;
         FUNCT3_XOR:     op = ALU_XOR;
         FUNCT3_SRL_SRA: op = alt ? ALU_SRA : ALU_SRL;
         FUNCT3_OR:      op = ALU_OR;
         default:        op = ALU_AND;
      endcase
      return op;
   endfunction

   function automatic alu_op_t muldiv_op_for(input logic [2:0] funct3);
      alu_op_t op;
      case (funct3)
         3'b000:  op = ALU_MUL;
         3'b001:  op = ALU_MULH;
         3'b010:  op = ALU_MULHSU;
         3'b011:  op = ALU_MULHU;
         3'b100:  op = ALU_DIV;
         3'b101:  op = ALU_DIVU;
         3'b110:  op = ALU_REM;
         default: op = ALU_REMU;
      endcase
      return op;
   endfunction

endpackage

// File: rtl/instr_alu.sv
// Combinational integer ALU shared by OP and OP_IMM. RV32M multiply/divide is
// present only when INSTR_COMPUTE_M_EXT_EN is defined.
module instr_alu
   import isa_types::*;
(
   input  alu_op_t         op,
   input  logic [XLEN-1:0] a,
   input  logic [XLEN-1:0] b,
   output logic [XLEN-1:0] result
);

   logic [4:0] shamt;
   assign shamt = b[4:0];

`ifdef INSTR_COMPUTE_M_EXT_EN
   logic              a_signed;
   logic              b_signed;
   logic [2*XLEN-1:0] mul_a;
   logic [2*XLEN-1:0] mul_b;
   logic [2*XLEN-1:0] product;
   logic              div_zero;
   logic              div_overflow;
   logic [XLEN-1:0]   b_safe;
   logic [XLEN-1:0]   quot_s;
   logic [XLEN-1:0]   rem_s;

   // One 64-bit multiplier; operand extension picks the MULH/MULHSU/MULHU flavour.
   assign a_signed = (op == ALU_MULH) || (op == ALU_MULHSU);
   assign b_signed = (op == ALU_MULH);
   assign mul_a    = {{XLEN{a_signed & a[XLEN-1]}}, a};
   assign mul_b    = {{XLEN{b_signed & b[XLEN-1]}}, b};
   assign product  = mul_a * mul_b;

   // Zero and MIN/-1 divisors are steered to 1 so the divider never sees an undefined case.
   assign div_zero     = (b == '0);
   assign div_overflow = (a == {1'b1, {(XLEN-1){1'b0}}}) && (b == '1);
   assign b_safe       = (div_zero || div_overflow) ? {{(XLEN-1){1'b0}}, 1'b1} : b;
   assign quot_s       = $signed(a) / $signed(b_safe);
   assign rem_s        = $signed(a) % $signed(b_safe);
`endif

   always_comb begin
      result = '0;
      case (op)
         ALU_ADD:  result = a + b;
         ALU_SUB:  result = a - b;
         ALU_SLL:  result = a << shamt;
         ALU_SLT:  result = {{(XLEN-1){1'b0}}, $signed(a) < $signed(b)};
         ALU_SLTU: result = {{(XLEN-1){1'b0}}, a < b};
         ALU_XOR:  result = a ^ b;
         ALU_SRL:  result = a >> shamt;
         ALU_SRA:  result = $unsigned($signed(a) >>> shamt);
         ALU_OR:   result = a | b;
         ALU_AND:  result = a & b;
`ifdef INSTR_COMPUTE_M_EXT_EN
         ALU_MUL:    result = product[XLEN-1:0];
         ALU_MULH,
         ALU_MULHSU,
         ALU_MULHU:  result = product[2*XLEN-1:XLEN];
         ALU_DIV:    result = div_zero ? '1 : (div_overflow ? a : quot_s);
         ALU_DIVU:   result = div_zero ? '1 : a / b_safe;
         ALU_REM:    result = div_zero ? a : (div_overflow ? '0 : rem_s);
         ALU_REMU:   result = div_zero ? a : a % b_safe;
`endif
         default:  result = '0;
      endcase
   end

endmodule

// File: rtl/instr_compute.sv
// Registered RV32I execute unit: store data, rd writeback and PC redirect, one
// cycle after sampling. INSTR_COMPUTE_M_EXT_EN enables RV32M on OP/funct7=0000001.
module instr_compute
   import isa_types::*;
(
   input  logic                 clk,
   input  logic                 rst_n,
   input  reg_state_t           reg_state,
   input  logic [XLEN-1:0]      load_val,
   input  decoded_instruction_t curr_instr,
   output logic [XLEN-1:0]      store_val,
   output logic                 store_enable,
   output logic [XLEN-1:0]      rd_out_val,
   output logic                 rd_out_enable,
   output logic [XLEN-1:0]      jump_target_addr,
   output logic                 jump_enable
);

`ifdef INSTR_COMPUTE_M_EXT_EN
   localparam bit M_EXT = 1'b1;
`else
   localparam bit M_EXT = 1'b0;
`endif

   logic [XLEN-1:0] rs1v;
   logic [XLEN-1:0] rs2v;
   logic [XLEN-1:0] pc;
   logic [XLEN-1:0] pc_plus4;
   alu_op_t         alu_op;
   logic [XLEN-1:0] alu_b;
   logic [XLEN-1:0] alu_result;
   logic            branch_taken;
   logic [XLEN-1:0] load_ext;

   logic [XLEN-1:0] next_store_val;
   logic            next_store_enable;
   logic [XLEN-1:0] next_rd_val;
   logic            next_rd_enable;
   logic [XLEN-1:0] next_target;
   logic            next_jump;

   // The store address is formed outside this unit, so s_imm has no consumer here.
   logic unused_s_imm;
   assign unused_s_imm = ^curr_instr.s_imm;

   assign rs1v     = (curr_instr.rs1 == 5'd0) ? '0 : reg_state.xregs[curr_instr.rs1];
   assign rs2v     = (curr_instr.rs2 == 5'd0) ? '0 : reg_state.xregs[curr_instr.rs2];
   assign pc       = reg_state.pc;
   assign pc_plus4 = pc + 32'd4;

   always_comb begin
      alu_b  = curr_instr.i_imm;
      alu_op = alu_op_for(curr_instr.funct3, curr_instr.funct7[5], 1'b0);
      if (curr_instr.opcode == OPCODE_OP) begin
         alu_b  = rs2v;
         alu_op = (curr_instr.funct7 == FUNCT7_MULDIV) ? muldiv_op_for(curr_instr.funct3)
                                                       : alu_op_for(curr_instr.funct3,
                                                                    curr_instr.funct7[5], 1'b1);
      end
   end

   instr_alu u_alu (
      .op     (alu_op),
      .a      (rs1v),
      .b      (alu_b),
      .result (alu_result)
   );

   always_comb begin
      branch_taken = 1'b0;
      case (curr_instr.funct3)
         FUNCT3_BEQ:  branch_taken = (rs1v == rs2v);
         FUNCT3_BNE:  branch_taken = (rs1v != rs2v);
         FUNCT3_BLT:  branch_taken = ($signed(rs1v) <  $signed(rs2v));
         FUNCT3_BGE:  branch_taken = ($signed(rs1v) >= $signed(rs2v));
         FUNCT3_BLTU: branch_taken = (rs1v <  rs2v);
         FUNCT3_BGEU: branch_taken = (rs1v >= rs2v);
         default:     branch_taken = 1'b0;
      endcase
   end

   // Reserved load widths fall through to a full-word load.
   always_comb begin
      case (curr_instr.funct3)
         FUNCT3_LB:  load_ext = {{(XLEN-8){load_val[7]}}, load_val[7:0]};
         FUNCT3_LH:  load_ext = {{(XLEN-16){load_val[15]}}, load_val[15:0]};
         FUNCT3_LBU: load_ext = {{(XLEN-8){1'b0}}, load_val[7:0]};
         FUNCT3_LHU: load_ext = {{(XLEN-16){1'b0}}, load_val[15:0]};
         default:    load_ext = load_val;
      endcase
   end

   always_comb begin
      next_store_val    = '0;
      next_store_enable = 1'b0;
      next_rd_val       = '0;
      next_rd_enable    = 1'b0;
      next_target       = '0;
      next_jump         = 1'b0;
      case (curr_instr.opcode)
         OPCODE_OP_IMM: begin
            next_rd_val    = alu_result;
            next_rd_enable = 1'b1;
         end
         OPCODE_OP: begin
            if (curr_instr.funct7 != FUNCT7_MULDIV || M_EXT) begin
               next_rd_val    = alu_result;
               next_rd_enable = 1'b1;
            end
         end
         OPCODE_LUI: begin
            next_rd_val    = curr_instr.u_imm;
            next_rd_enable = 1'b1;
         end
         OPCODE_AUIPC: begin
            next_rd_val    = pc + curr_instr.u_imm;
            next_rd_enable = 1'b1;
         end
         OPCODE_JAL: begin
            next_rd_val    = pc_plus4;
            next_rd_enable = 1'b1;
            next_target    = pc + curr_instr.j_imm;
            next_jump      = 1'b1;
         end
         OPCODE_JALR: begin
            next_rd_val    = pc_plus4;
            next_rd_enable = 1'b1;
            next_target    = (rs1v + curr_instr.i_imm) & ~{{(XLEN-1){1'b0}}, 1'b1};
            next_jump      = 1'b1;
         end
         OPCODE_BRANCH: begin
            next_jump   = branch_taken;
            next_target = branch_taken ? pc + curr_instr.b_imm : '0;
         end
         OPCODE_LOAD: begin
            next_rd_val    = load_ext;
            next_rd_enable = 1'b1;
         end
         OPCODE_STORE: begin
            next_store_val    = rs2v;
            next_store_enable = 1'b1;
         end
         default: ;
      endcase
      if (curr_instr.rd == 5'd0) begin
         next_rd_val    = '0;
         next_rd_enable = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         store_val        <= '0;
         store_enable     <= 1'b0;
         rd_out_val       <= '0;
         rd_out_enable    <= 1'b0;
         jump_target_addr <= '0;
         jump_enable      <= 1'b0;
      end else begin
         store_val        <= next_store_val;
         store_enable     <= next_store_enable;
         rd_out_val       <= next_rd_val;
         rd_out_enable    <= next_rd_enable;
         jump_target_addr <= next_target;
         jump_enable      <= next_jump;
      end
   end

endmodule

// File: tb/tb_instr_compute.sv
// Directed scoreboard bench for instr_compute; RV32M expectations follow
// INSTR_COMPUTE_M_EXT_EN, otherwise funct7=0000001 must produce all-zero outputs.
module tb_instr_compute;
   import isa_types::*;

`ifdef INSTR_COMPUTE_M_EXT_EN
   localparam bit M_ON = 1'b1;
`else
   localparam bit M_ON = 1'b0;
`endif

   logic                 clk;
   logic                 rst_n;
   reg_state_t           regs;
   logic [XLEN-1:0]      load_val;
   decoded_instruction_t ins;
   logic [XLEN-1:0]      store_val;
   logic                 store_enable;
   logic [XLEN-1:0]      rd_out_val;
   logic                 rd_out_enable;
   logic [XLEN-1:0]      jump_target_addr;
   logic                 jump_enable;

   typedef struct {
      string       tag;
      logic [31:0] sv;
      logic        se;
      logic [31:0] rv;
      logic        re;
      logic [31:0] jt;
      logic        je;
   } exp_t;

   exp_t sb[$];
   int   vectors = 0;
   int   miscompares = 0;

   instr_compute dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .reg_state        (regs),
      .load_val         (load_val),
      .curr_instr       (ins),
      .store_val        (store_val),
      .store_enable     (store_enable),
      .rd_out_val       (rd_out_val),
      .rd_out_enable    (rd_out_enable),
      .jump_target_addr (jump_target_addr),
      .jump_enable      (jump_enable)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic decoded_instruction_t mk(input logic [6:0] op, input logic [4:0] rd,
                                               input logic [4:0] rs1, input logic [4:0] rs2,
                                               input logic [2:0] f3, input logic [6:0] f7);
      decoded_instruction_t d;
      d.opcode = op;
      d.rd     = rd;
      d.rs1    = rs1;
      d.rs2    = rs2;
      d.funct3 = f3;
      d.funct7 = f7;
      d.i_imm  = 32'h0000_0AA0;
      d.s_imm  = 32'h0000_0BB0;
      d.b_imm  = 32'h0000_0CC0;
      d.u_imm  = 32'h0DD0_0000;
      d.j_imm  = 32'h0000_0EE0;
      return d;
   endfunction

   function automatic logic [31:0] mval(input logic [31:0] v);
      return M_ON ? v : 32'h0;
   endfunction

   task automatic compare(input string tag, input string field,
                          input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("[TB] FAIL %s/%s observed=%h expected=%h", tag, field, obs, exp);
      end
   endtask

   task automatic applyStimulus(input string tag, input decoded_instruction_t d,
                                input logic [31:0] ld,
                                input logic [31:0] sv, input logic se,
                                input logic [31:0] rv, input logic re,
                                input logic [31:0] jt, input logic je);
      exp_t e;
      @(negedge clk);
      ins      = d;
      load_val = ld;
      e.tag = tag; e.sv = sv; e.se = se; e.rv = rv; e.re = re; e.jt = jt; e.je = je;
      sb.push_back(e);
   endtask

   task automatic checkOutput();
      exp_t e;
      @(posedge clk);
      #1;
      if (sb.size() == 0) begin
         vectors++;
         miscompares++;
         $error("[TB] FAIL scoreboard_empty observed=0 expected=1");
      end else begin
         e = sb.pop_front();
         compare(e.tag, "store_val",        store_val,        e.sv);
         compare(e.tag, "store_enable",     {31'b0, store_enable},  {31'b0, e.se});
         compare(e.tag, "rd_out_val",       rd_out_val,       e.rv);
         compare(e.tag, "rd_out_enable",    {31'b0, rd_out_enable}, {31'b0, e.re});
         compare(e.tag, "jump_target_addr", jump_target_addr, e.jt);
         compare(e.tag, "jump_enable",      {31'b0, jump_enable},   {31'b0, e.je});
      end
   endtask

   task automatic checkZero(input string tag);
      compare(tag, "store_val",        store_val,                 32'h0);
      compare(tag, "store_enable",     {31'b0, store_enable},     32'h0);
      compare(tag, "rd_out_val",       rd_out_val,                32'h0);
      compare(tag, "rd_out_enable",    {31'b0, rd_out_enable},    32'h0);
      compare(tag, "jump_target_addr", jump_target_addr,          32'h0);
      compare(tag, "jump_enable",      {31'b0, jump_enable},      32'h0);
   endtask

   task automatic step(input string tag, input decoded_instruction_t d, input logic [31:0] ld,
                       input logic [31:0] sv, input logic se, input logic [31:0] rv,
                       input logic re, input logic [31:0] jt, input logic je);
      applyStimulus(tag, d, ld, sv, se, rv, re, jt, je);
      checkOutput();
   endtask

   initial begin
      decoded_instruction_t d;
      regs = '0;
      regs.xregs[0]  = 32'hDEAD_BEEF;
      regs.xregs[1]  = 32'h0000_0100;
      regs.xregs[2]  = 32'h0000_0007;
      regs.xregs[4]  = 32'h8000_0000;
      regs.xregs[5]  = 32'd33;
      regs.xregs[7]  = 32'h0000_0001;
      regs.xregs[8]  = 32'hFFFF_FFFF;
      regs.xregs[10] = 32'h0000_0101;
      regs.pc        = 32'h0000_0040;
      load_val = 32'h0;
      rst_n = 1'b0;
      d = mk(OPCODE_OP_IMM, 5'd3, 5'd1, 5'd0, 3'b000, 7'h00);
      d.i_imm = 32'hFFFF_FFFF;
      ins = d;

      repeat (2) @(posedge clk);
      #1;
      checkZero("reset_hold");
      @(negedge clk);
      rst_n = 1'b1;

      d = mk(OPCODE_STORE, 5'd5, 5'd1, 5'd2, FUNCT3_SB, 7'h00);
      d.s_imm = 32'h10;
      step("sb", d, 32'h0, 32'h7, 1'b1, 32'h0, 1'b0, 32'h0, 1'b0);

      d = mk(OPCODE_OP_IMM, 5'd3, 5'd1, 5'd0, 3'b000, 7'h7F);
      d.i_imm = 32'hFFFF_FFFF;
      step("addi", d, 32'h0, 32'h0, 1'b0, 32'h0000_00FF, 1'b1, 32'h0, 1'b0);

      // Outputs are non-zero now; pull reset low mid-cycle and expect an immediate clear.
      #2;
      rst_n = 1'b0;
      #1;
      checkZero("async_reset");
      @(posedge clk);
      #1;
      checkZero("reset_held_edge");
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      checkZero("after_release");

      d.rd = 5'd0;
      step("addi_rd0", d, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);

      d = mk(OPCODE_OP_IMM, 5'd3, 5'd1, 5'd0, FUNCT3_XOR, 7'h7F);
      d.i_imm = 32'hFFFF_F0F0;
      step("xori", d, 32'h0, 32'h0, 1'b0, 32'hFFFF_F1F0, 1'b1, 32'h0, 1'b0);

      d = mk(OPCODE_OP_IMM, 5'd6, 5'd4, 5'd0, FUNCT3_SRL_SRA, 7'h20);
      d.i_imm = 32'h0000_0404;
      step("srai", d, 32'h0, 32'h0, 1'b0, 32'hF800_0000, 1'b1, 32'h0, 1'b0);

      step("add_x0", mk(OPCODE_OP, 5'd5, 5'd0, 5'd2, FUNCT3_ADD_SUB, 7'h00), 32'h0,
           32'h0, 1'b0, 32'h7, 1'b1, 32'h0, 1'b0);
      step("sub", mk(OPCODE_OP, 5'd5, 5'd1, 5'd2, FUNCT3_ADD_SUB, 7'h20), 32'h0,
           32'h0, 1'b0, 32'h0000_00F9, 1'b1, 32'h0, 1'b0);
      step("sra", mk(OPCODE_OP, 5'd6, 5'd4, 5'd5, FUNCT3_SRL_SRA, 7'h20), 32'h0,
           32'h0, 1'b0, 32'hC000_0000, 1'b1, 32'h0, 1'b0);
      step("srl", mk(OPCODE_OP, 5'd6, 5'd4, 5'd5, FUNCT3_SRL_SRA, 7'h00), 32'h0,
           32'h0, 1'b0, 32'h4000_0000, 1'b1, 32'h0, 1'b0);
      step("sltu", mk(OPCODE_OP, 5'd9, 5'd7, 5'd8, FUNCT3_SLTU, 7'h00), 32'h0,
           32'h0, 1'b0, 32'h1, 1'b1, 32'h0, 1'b0);
      step("sltu_rev", mk(OPCODE_OP, 5'd9, 5'd8, 5'd7, FUNCT3_SLTU, 7'h00), 32'h0,
           32'h0, 1'b0, 32'h0, 1'b1, 32'h0, 1'b0);
      step("slt", mk(OPCODE_OP, 5'd9, 5'd8, 5'd7, FUNCT3_SLT, 7'h00), 32'h0,
           32'h0, 1'b0, 32'h1, 1'b1, 32'h0, 1'b0);

      d = mk(OPCODE_BRANCH, 5'd5, 5'd1, 5'd2, FUNCT3_BNE, 7'h00);
      d.b_imm = 32'hFFFF_FFF8;
      step("bne_taken", d, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0000_0038, 1'b1);
      d.rs1 = 5'd2;
      step("bne_equal", d, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);

      d = mk(OPCODE_BRANCH, 5'd5, 5'd4, 5'd7, FUNCT3_BLT, 7'h00);
      d.b_imm = 32'h20;
      step("blt", d, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0000_0060, 1'b1);
      d.funct3 = FUNCT3_BGE;
      step("bge", d, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
      d.funct3 = FUNCT3_BGEU;
      step("bgeu", d, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0000_0060, 1'b1);

      d = mk(OPCODE_JAL, 5'd1, 5'd0, 5'd0, 3'b000, 7'h00);
      d.j_imm = 32'h100;
      step("jal", d, 32'h0, 32'h0, 1'b0, 32'h0000_0044, 1'b1, 32'h0000_0140, 1'b1);

      d = mk(OPCODE_JALR, 5'd11, 5'd10, 5'd0, 3'b000, 7'h00);
      d.i_imm = 32'h4;
      step("jalr", d, 32'h0, 32'h0, 1'b0, 32'h0000_0044, 1'b1, 32'h0000_0104, 1'b1);
      d.rd = 5'd10;
      step("jalr_rd_eq_rs1", d, 32'h0, 32'h0, 1'b0, 32'h0000_0044, 1'b1, 32'h0000_0104, 1'b1);

      d = mk(OPCODE_LUI, 5'd2, 5'd0, 5'd0, 3'b000, 7'h00);
      d.u_imm = 32'h1234_5000;
      step("lui", d, 32'h0, 32'h0, 1'b0, 32'h1234_5000, 1'b1, 32'h0, 1'b0);
      d.opcode = OPCODE_AUIPC;
      step("auipc", d, 32'h0, 32'h0, 1'b0, 32'h1234_5040, 1'b1, 32'h0, 1'b0);

      step("lb", mk(OPCODE_LOAD, 5'd12, 5'd1, 5'd0, FUNCT3_LB, 7'h00), 32'h0000_0080,
           32'h0, 1'b0, 32'hFFFF_FF80, 1'b1, 32'h0, 1'b0);
      step("lbu", mk(OPCODE_LOAD, 5'd12, 5'd1, 5'd0, FUNCT3_LBU, 7'h00), 32'h0000_0080,
           32'h0, 1'b0, 32'h0000_0080, 1'b1, 32'h0, 1'b0);
      step("lh", mk(OPCODE_LOAD, 5'd12, 5'd1, 5'd0, FUNCT3_LH, 7'h00), 32'h1234_8000,
           32'h0, 1'b0, 32'hFFFF_8000, 1'b1, 32'h0, 1'b0);
      step("lhu", mk(OPCODE_LOAD, 5'd12, 5'd1, 5'd0, FUNCT3_LHU, 7'h00), 32'h1234_8000,
           32'h0, 1'b0, 32'h0000_8000, 1'b1, 32'h0, 1'b0);
      step("lw", mk(OPCODE_LOAD, 5'd12, 5'd1, 5'd0, FUNCT3_LW, 7'h00), 32'h1234_8000,
           32'h0, 1'b0, 32'h1234_8000, 1'b1, 32'h0, 1'b0);
      step("load_f3_011", mk(OPCODE_LOAD, 5'd12, 5'd1, 5'd0, 3'b011, 7'h00), 32'h1234_8000,
           32'h0, 1'b0, 32'h1234_8000, 1'b1, 32'h0, 1'b0);
      step("lb_rd0", mk(OPCODE_LOAD, 5'd0, 5'd1, 5'd0, FUNCT3_LB, 7'h00), 32'h0000_0080,
           32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);

      step("unknown_op", mk(7'h7F, 5'd3, 5'd1, 5'd2, 3'b000, 7'h00), 32'hFFFF_FFFF,
           32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);

      step("mul", mk(OPCODE_OP, 5'd13, 5'd1, 5'd2, 3'b000, 7'h01), 32'h0,
           32'h0, 1'b0, mval(32'h0000_0700), M_ON, 32'h0, 1'b0);
      step("mulh", mk(OPCODE_OP, 5'd13, 5'd4, 5'd4, 3'b001, 7'h01), 32'h0,
           32'h0, 1'b0, mval(32'h4000_0000), M_ON, 32'h0, 1'b0);
      step("mulhsu", mk(OPCODE_OP, 5'd13, 5'd8, 5'd7, 3'b010, 7'h01), 32'h0,
           32'h0, 1'b0, mval(32'hFFFF_FFFF), M_ON, 32'h0, 1'b0);
      step("mulhu", mk(OPCODE_OP, 5'd13, 5'd4, 5'd8, 3'b011, 7'h01), 32'h0,
           32'h0, 1'b0, mval(32'h7FFF_FFFF), M_ON, 32'h0, 1'b0);
      step("div_zero", mk(OPCODE_OP, 5'd13, 5'd1, 5'd0, 3'b100, 7'h01), 32'h0,
           32'h0, 1'b0, mval(32'hFFFF_FFFF), M_ON, 32'h0, 1'b0);
      step("remu_zero", mk(OPCODE_OP, 5'd13, 5'd1, 5'd0, 3'b111, 7'h01), 32'h0,
           32'h0, 1'b0, mval(32'h0000_0100), M_ON, 32'h0, 1'b0);
      step("div_ovf", mk(OPCODE_OP, 5'd13, 5'd4, 5'd8, 3'b100, 7'h01), 32'h0,
           32'h0, 1'b0, mval(32'h8000_0000), M_ON, 32'h0, 1'b0);
      step("rem_ovf", mk(OPCODE_OP, 5'd13, 5'd4, 5'd8, 3'b110, 7'h01), 32'h0,
           32'h0, 1'b0, 32'h0, M_ON, 32'h0, 1'b0);
      step("divu", mk(OPCODE_OP, 5'd13, 5'd1, 5'd2, 3'b101, 7'h01), 32'h0,
           32'h0, 1'b0, mval(32'h0000_0024), M_ON, 32'h0, 1'b0);
      step("rem", mk(OPCODE_OP, 5'd13, 5'd1, 5'd2, 3'b110, 7'h01), 32'h0,
           32'h0, 1'b0, mval(32'h0000_0004), M_ON, 32'h0, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
